// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words written to CPU memory, holding the CPU in reset until done.
// Write lands 1 cycle after each 4th byte; in_ready stays high through the whole load so the stream never stalls.
module imem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0,
  parameter int RESET_HOLD = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   num_words_i,
  input  logic [7:0]            in_byte_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  cpu_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_e;

  localparam logic [ADDR_WIDTH+1:0] CAPACITY = (ADDR_WIDTH+2)'((1 << ADDR_WIDTH) - BASE_ADDR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic [ADDR_WIDTH:0]   widx_q, widx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           pack_q, pack_d;
  logic [7:0]            hold_q, hold_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;
  logic                  accept;

  assign accept = in_valid_i && in_ready_q && (state_q == LOAD);

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    widx_d      = widx_q;
    bcnt_d      = bcnt_q;
    pack_d      = pack_q;
    hold_d      = hold_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE, RUN: begin
        if (start_i) begin
          // Capacity check comes first so an oversized image never reaches LOAD.
          if ({1'b0, num_words_i} > CAPACITY) begin
            overflow_d = 1'b1;
            state_d    = IDLE;
          end else if (num_words_i == '0) begin
            hold_d  = 8'(RESET_HOLD);
            state_d = HOLD;
          end else begin
            num_d      = num_words_i;
            overflow_d = 1'b0;
            widx_d     = '0;
            bcnt_d     = '0;
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q != 2'd3) begin
            pack_d[{bcnt_q, 3'b000} +: 8] = in_byte_i;
          end else begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {in_byte_i, pack_q};
            mem_addr_d  = ADDR_WIDTH'(BASE_ADDR) + widx_q[ADDR_WIDTH-1:0];
            widx_d      = widx_q + 1'b1;
            if (widx_q == num_q - 1'b1) begin
              hold_d  = 8'(RESET_HOLD);
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (hold_q == 8'd0) state_d = RUN;
        else                hold_d  = hold_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the next state so they align with state_q.
    in_ready_d  = (state_d == LOAD);
    cpu_reset_d = (state_d != RUN);
    busy_d      = (state_d == LOAD) || (state_d == HOLD);
    done_d      = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      num_q       <= '0;
      widx_q      <= '0;
      bcnt_q      <= '0;
      pack_q      <= '0;
      hold_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      widx_q      <= widx_d;
      bcnt_q      <= bcnt_d;
      pack_q      <= pack_d;
      hold_q      <= hold_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cpu_reset_o = cpu_reset_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random-gap byte streams checked against words/addresses computed from the image bytes.
module tb_imem_loader;
  localparam int AW   = 12;
  localparam int BASE = 0;
  localparam int RH   = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [AW:0]   num_words_i = '0;
  logic [7:0]    in_byte_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o, mem_we_o, cpu_reset_o, busy_o, done_o, overflow_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .RESET_HOLD(RH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .num_words_i(num_words_i),
    .in_byte_i(in_byte_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .cpu_reset_o(cpu_reset_o), .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int we_pulses = 0;

  logic [7:0]    img[$];
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_data;

  always @(negedge clk_i) if (mem_we_o === 1'b1) we_pulses++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_cycle(input logic exp_rdy);
    chk("in_ready", 64'(in_ready_o), 64'(exp_rdy));
    chk("mem_we", 64'(mem_we_o), 64'(exp_we));
    chk("mem_addr", 64'(mem_addr_o), 64'(exp_addr));
    if (exp_we) chk("mem_wdata", 64'(mem_wdata_o), 64'(exp_data));
  endtask

  task automatic make_img(input int n);
    img.delete();
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
  endtask

  // Streams img as an n-word image; fixgap >= 0 forces that many idle cycles before every byte.
  task automatic do_load(input int n, input int maxgap, input int fixgap);
    int g;
    int cnt;
    start_i     = 1'b1;
    num_words_i = (AW+1)'(n);
    step();
    start_i = 1'b0;
    chk("start_cpu_reset", 64'(cpu_reset_o), 64'd1);
    chk("start_done", 64'(done_o), 64'd0);
    chk("start_busy", 64'(busy_o), 64'd1);
    chk("start_ovf", 64'(overflow_o), 64'd0);
    exp_we = 1'b0;
    for (int k = 0; k < 4 * n; k++) begin
      g = (fixgap >= 0) ? fixgap : int'($urandom_range(maxgap, 0));
      repeat (g) begin
        check_cycle(1'b1);
        in_valid_i = 1'b0;
        in_byte_i  = 8'($urandom);
        step();
        exp_we = 1'b0;
      end
      check_cycle(1'b1);
      in_valid_i = 1'b1;
      in_byte_i  = img[k];
      step();
      if (k % 4 == 3) begin
        exp_we   = 1'b1;
        exp_addr = AW'(BASE + k / 4);
        exp_data = {img[k], img[k-1], img[k-2], img[k-3]};
      end else begin
        exp_we = 1'b0;
      end
    end
    in_valid_i = 1'b0;
    check_cycle(1'b0);
    chk("write_busy", 64'(busy_o), 64'd1);
    exp_we = 1'b0;
    cnt = 0;
    while (cpu_reset_o === 1'b1 && cnt < 40) begin
      start_i     = 1'($urandom_range(1, 0));
      num_words_i = (AW+1)'($urandom);
      in_valid_i  = 1'($urandom_range(1, 0));
      step();
      cnt++;
      check_cycle(1'b0);
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("release_lat", 64'(cnt), 64'(RH + 1));
    chk("run_done", 64'(done_o), 64'd1);
    chk("run_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int p0;
    exp_we   = 1'b0;
    exp_addr = AW'(BASE);
    exp_data = '0;

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_mem_we", 64'(mem_we_o), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'(BASE));
    chk("rst_wdata", 64'(mem_wdata_o), 64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    rst_ni = 1'b1;
    step();

    // Oversized image: flagged, nothing starts.
    start_i = 1'b1;
    num_words_i = (AW+1)'((1 << AW) - BASE + 1);
    in_valid_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("ovf_flag", 64'(overflow_o), 64'd1);
    chk("ovf_in_ready", 64'(in_ready_o), 64'd0);
    chk("ovf_cpu_reset", 64'(cpu_reset_o), 64'd1);
    chk("ovf_busy", 64'(busy_o), 64'd0);
    repeat (3) step();
    chk("ovf_stays_idle", 64'({in_ready_o, busy_o, done_o}), 64'd0);
    in_valid_i = 1'b0;

    // Fixed two-word image, back-to-back then with 3-cycle gaps.
    img = {8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h01, 8'h8C};
    do_load(2, 0, 0);
    p0 = we_pulses;
    do_load(2, 0, 3);
    chk("gap_we_pulses", 64'(we_pulses - p0), 64'd2);

    // Empty image goes straight to HOLD.
    p0 = we_pulses;
    start_i = 1'b1;
    num_words_i = '0;
    step();
    start_i = 1'b0;
    chk("zero_busy", 64'(busy_o), 64'd1);
    cnt = 0;
    while (done_o !== 1'b1 && cnt < 40) begin
      chk("zero_in_ready", 64'(in_ready_o), 64'd0);
      in_valid_i = 1'($urandom_range(1, 0));
      step();
      cnt++;
    end
    in_valid_i = 1'b0;
    chk("zero_lat", 64'(cnt), 64'(RH + 1));
    chk("zero_no_write", 64'(we_pulses - p0), 64'd0);

    // Reset in the middle of word 0 must leave no trace.
    start_i = 1'b1;
    num_words_i = (AW+1)'(1);
    step();
    start_i = 1'b0;
    in_valid_i = 1'b1;
    in_byte_i = 8'h55;
    step();
    in_byte_i = 8'h66;
    step();
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_in_ready", 64'(in_ready_o), 64'd0);
    chk("arst_cpu_reset", 64'(cpu_reset_o), 64'd1);
    chk("arst_mem_addr", 64'(mem_addr_o), 64'(BASE));
    step();
    rst_ni = 1'b1;
    exp_addr = AW'(BASE);
    step();
    img = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(1, 2, -1);

    // Random reloads from RUN.
    repeat (6) begin
      cnt = int'($urandom_range(5, 1));
      make_img(cnt);
      do_load(cnt, 2, -1);
    end

    // Exactly full memory is accepted and ends at the last address.
    make_img((1 << AW) - BASE);
    do_load((1 << AW) - BASE, 0, 0);
    chk("full_last_addr", 64'(mem_addr_o), 64'((1 << AW) - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
